// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// Sits after the ALU result register and feeds the 4-bit-per-digit
// seven-segment decoders. One operand bit is consumed per clock.
//
// Ports:
//   Clk       - system clock, rising edge
//   Reset_n   - asynchronous active-low reset
//   start     - conversion request, only looked at while idle
//   bin_in    - unsigned operand, captured on the accepting edge
//   busy      - high while a conversion is running
//   done      - one-cycle pulse when bcd_out/overflow have been updated
//   bcd_out   - packed BCD result, digit k in bits [4k+3:4k] (k=0 = units)
//   overflow  - last operand did not fit in DIGITS decimal digits
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   opnd_q,     opnd_d;
    logic [BW-1:0]      scratch_q,  scratch_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ovf_acc_q,  ovf_acc_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [BW-1:0]      bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    // Add-3 correction applied to every scratch digit before the shift.
    // A digit of 5..9 becomes 8..12, so the 4-bit add never wraps.
    logic [BW-1:0] adj_digits;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj_digits[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                         ? scratch_q[4*gi +: 4] + 4'd3
                                         : scratch_q[4*gi +: 4];
        end
    endgenerate

    // The whole {digits, operand} chain moves left by one. The bit that
    // falls off the top digit means the value has outgrown DIGITS digits.
    logic [BW+WIDTH-1:0] shifted;
    logic                shift_out;

    assign shifted   = {adj_digits, opnd_q} << 1;
    assign shift_out = adj_digits[BW-1];

    // Saturation pattern shown when the operand does not fit.
    logic [BW-1:0] all_nines;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nines
            assign all_nines[4*gi +: 4] = 4'h9;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opnd_d    = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    ovf_acc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                scratch_d = shifted[BW+WIDTH-1:WIDTH];
                opnd_d    = shifted[WIDTH-1:0];
                ovf_acc_d = ovf_acc_q | shift_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                bcd_d      = ovf_acc_q ? all_nines : scratch_q;
                overflow_d = ovf_acc_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            opnd_q     <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_acc_q  <= ovf_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Self-checking bench for bin_to_bcd_seq. Two instances (3 digits and
// 2 digits) share all stimulus; expected results are computed with plain
// decimal arithmetic, queued at launch and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;

    logic        busy1, done1, ovf1;
    logic [11:0] bcd1;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .CNT_W(5)) dut1 (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy1),
        .done     (done1),
        .bcd_out  (bcd1),
        .overflow (ovf1)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .CNT_W(5)) dut2 (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy2),
        .done     (done2),
        .bcd_out  (bcd2),
        .overflow (ovf2)
    );

    logic [12:0] q1[$];   // {overflow, 3 BCD digits}
    logic [8:0]  q2[$];   // {overflow, 2 BCD digits}

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ndone1 = 0;
    int ndone2 = 0;

    always @(negedge clk) begin
        if (done1 === 1'b1) ndone1++;
        if (done2 === 1'b1) ndone2++;
    end

    // Decimal reference: {overflow, packed BCD}, saturating to all nines.
    function automatic logic [12:0] model(input int v, input int nd);
        logic [11:0] r;
        int lim;
        int t;
        r   = '0;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        lim = lim - 1;
        if (v > lim) begin
            for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'd9;
            return {1'b1, r};
        end
        t = v;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_exp(input logic [7:0] v);
        logic [12:0] m2;
        q1.push_back(model(int'(v), 3));
        m2 = model(int'(v), 2);
        q2.push_back({m2[12], m2[7:0]});
    endtask

    // Presents one start pulse; returns the cycle index of the accept edge.
    task automatic launch(input logic [7:0] v, input bit push, output int e0);
        bin_in = v;
        start  = 1'b1;
        if (push) push_exp(v);
        tick();
        e0     = cyc;
        start  = 1'b0;
        bin_in = ~v;   // later changes must not disturb the running conversion
    endtask

    task automatic await_done(input int e0, input string tag);
        logic [12:0] e1;
        logic [8:0]  e2;
        while (done1 !== 1'b1 && (cyc - e0) < 30) tick();
        chk({tag, " done1"}, 32'(done1), 32'd1);
        chk({tag, " done2"}, 32'(done2), 32'd1);
        chk({tag, " latency"}, 32'(cyc - e0), 32'd9);
        if (q1.size() == 0 || q2.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            $display("conv %s: dut1 bcd=%03h ovf=%0b (exp %03h/%0b)  dut2 bcd=%02h ovf=%0b (exp %02h/%0b)",
                     tag, bcd1, ovf1, e1[11:0], e1[12], bcd2, ovf2, e2[7:0], e2[8]);
            chk({tag, " bcd1"}, 32'(bcd1), 32'(e1[11:0]));
            chk({tag, " ovf1"}, 32'(ovf1), 32'(e1[12]));
            chk({tag, " bcd2"}, 32'(bcd2), 32'(e2[7:0]));
            chk({tag, " ovf2"}, 32'(ovf2), 32'(e2[8]));
        end
    endtask

    initial begin
        int e0;
        int e1;
        int nb;
        int n0;
        logic [7:0] vals [3];

        vals[0] = 8'd0;
        vals[1] = 8'd99;
        vals[2] = 8'd100;

        // Reset state
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (3) tick();
        chk("rst busy", 32'(busy1), 32'd0);
        chk("rst done", 32'(done1), 32'd0);
        chk("rst bcd1", 32'(bcd1), 32'd0);
        chk("rst ovf1", 32'(ovf1), 32'd0);
        chk("rst bcd2", 32'(bcd2), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 255: busy width, latency, single done cycle
        launch(8'd255, 1'b1, e0);
        chk("255 busy", 32'(busy1), 32'd1);
        nb = 1;
        while (done1 !== 1'b1 && (cyc - e0) < 30) begin
            tick();
            if (busy1 === 1'b1) nb++;
        end
        await_done(e0, "255");
        chk("255 busy cycles", 32'(nb), 32'd9);
        chk("255 busy after", 32'(busy1), 32'd0);
        tick();
        chk("255 done pulse", 32'(done1), 32'd0);

        // Plain conversions
        for (int i = 0; i < 3; i++) begin
            launch(vals[i], 1'b1, e0);
            await_done(e0, $sformatf("v%0d", vals[i]));
            tick();
            chk("done pulse", 32'(done1), 32'd0);
        end

        // Start while busy is ignored
        n0 = ndone1;
        launch(8'd42, 1'b1, e0);
        tick();
        tick();
        bin_in = 8'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        await_done(e0, "42ign");
        repeat (15) tick();
        chk("42 done count", 32'(ndone1 - n0), 32'd1);
        chk("42 idle", 32'(busy1), 32'd0);

        // Back-to-back with start held high
        bin_in = 8'd10;
        start  = 1'b1;
        push_exp(8'd10);
        tick();
        e0 = cyc;
        bin_in = 8'd200;
        push_exp(8'd200);
        await_done(e0, "b2b10");
        tick();
        e1 = cyc;
        start = 1'b0;
        chk("b2b reaccept busy", 32'(busy1), 32'd1);
        await_done(e1, "b2b200");
        tick();
        chk("b2b done pulse", 32'(done1), 32'd0);

        launch(8'd57, 1'b1, e0);
        await_done(e0, "57");
        tick();

        // Asynchronous reset in the 4th shift cycle
        n0 = ndone1;
        launch(8'd123, 1'b0, e0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort done", 32'(done1), 32'd0);
        chk("abort bcd1", 32'(bcd1), 32'd0);
        chk("abort ovf1", 32'(ovf1), 32'd0);
        chk("abort bcd2", 32'(bcd2), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("abort no done", 32'(ndone1 - n0), 32'd0);
        launch(8'd5, 1'b1, e0);
        await_done(e0, "5");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
